// File: rtl/aesl_deadlock_stall_monitor_if.sv
// rtl/aesl_deadlock_stall_monitor_if.sv - deadlock report stream interface
// One beat per blocked AXIS port or process instance captured at detection.
interface aesl_deadlock_stall_monitor_if #(
  parameter int IDX_W = 8
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic             rpt_kind;
  logic [IDX_W-1:0] rpt_idx;
  logic             rpt_last;

  modport master (
    output rpt_valid,
    output rpt_kind,
    output rpt_idx,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_kind,
    input  rpt_idx,
    input  rpt_last,
    output rpt_ready
  );
endinterface

// File: rtl/aesl_deadlock_stall_monitor.sv
// rtl/aesl_deadlock_stall_monitor.sv - HLS dataflow kernel deadlock monitor
// Counts consecutive stall cycles, latches a snapshot on deadlock and streams the blocked entries.
module aesl_deadlock_stall_monitor #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 3,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 8
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  thresh,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block,
  output logic [7:0]        detect_cnt,
  aesl_deadlock_stall_monitor_if.master rpt
);

  localparam int N_TOT = N_AXIS + N_INST;
  localparam int PTR_W = (N_TOT > 1) ? $clog2(N_TOT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] thr_eff;
  logic [N_TOT-1:0] snap_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_sub;
  logic             block_q;
  logic [7:0]       det_q;
  logic             valid_q;
  logic             kind_q;
  logic             last_q;
  logic [IDX_W-1:0] idx_q;
  logic             stall;
  logic             hit;
  logic             cur_set;
  logic             cur_inst;
  logic             higher_set;

  // An all-idle kernel has finished, so it is never treated as stalled.
  always_comb begin
    stall   = ~&inst_idle_sigs & &(inst_idle_sigs | inst_block_sigs)
              & (|axis_block_sigs | |inst_block_sigs);
    thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    hit     = enable & stall & (cnt_d >= thr_eff);
  end

  // Snapshot is flattened as {inst, axis}; the scan pointer walks it upward.
  always_comb begin
    cur_set    = snap_q[ptr_q];
    cur_inst   = (ptr_q >= PTR_W'(N_AXIS));
    ptr_sub    = cur_inst ? ptr_q - PTR_W'(N_AXIS) : ptr_q;
    ptr_inc    = ptr_q + PTR_W'(1);
    higher_set = 1'b0;
    for (int i = 0; i < N_TOT; i++) begin
      if ((i > int'(ptr_q)) && snap_q[i]) higher_set = 1'b1;
    end
  end

  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset_n) begin
    if (!kernel_monitor_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      ptr_q   <= '0;
      block_q <= 1'b0;
      det_q   <= '0;
      valid_q <= 1'b0;
      kind_q  <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      block_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            block_q <= 1'b1;
            snap_q  <= {inst_block_sigs, axis_block_sigs};
            if (det_q != 8'hFF) det_q <= det_q + 8'd1;
            cnt_q   <= '0;
            ptr_q   <= '0;
            state_q <= S_SCAN;
          end else if (enable && stall) begin
            cnt_q <= cnt_d;
          end else begin
            cnt_q <= '0;
          end
        end
        S_SCAN: begin
          if (cur_set) begin
            valid_q <= 1'b1;
            kind_q  <= cur_inst;
            idx_q   <= IDX_W'(ptr_sub);
            last_q  <= ~higher_set;
            state_q <= S_EMIT;
          end else if (!higher_set) begin
            state_q <= S_DONE;
          end else begin
            ptr_q <= ptr_inc;
          end
        end
        S_EMIT: begin
          if (rpt.rpt_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              state_q <= S_DONE;
            end else begin
              ptr_q   <= ptr_inc;
              state_q <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign block         = block_q;
  assign detect_cnt    = det_q;
  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_kind  = kind_q;
  assign rpt.rpt_idx   = idx_q;
  assign rpt.rpt_last  = last_q;

endmodule

// File: tb/tb_aesl_deadlock_stall_monitor.sv
// tb/tb_aesl_deadlock_stall_monitor.sv - scoreboard bench for the deadlock monitor
// Stimulus pushes expected report beats; a negedge monitor pops them on each handshake.
module tb_aesl_deadlock_stall_monitor;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [15:0] thresh;
  logic [1:0]  axis_block;
  logic [2:0]  inst_idle;
  logic [2:0]  inst_block;
  logic        block;
  logic [7:0]  detect_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [9:0] exp_q[$];

  aesl_deadlock_stall_monitor_if #(.IDX_W(8)) rpt_if ();

  aesl_deadlock_stall_monitor #(
    .N_AXIS(2), .N_INST(3), .CNT_W(16), .IDX_W(8)
  ) dut (
    .kernel_monitor_clock  (clk),
    .kernel_monitor_reset_n(rst_n),
    .enable                (enable),
    .clear                 (clear),
    .thresh                (thresh),
    .axis_block_sigs       (axis_block),
    .inst_idle_sigs        (inst_idle),
    .inst_block_sigs       (inst_block),
    .block                 (block),
    .detect_cnt            (detect_cnt),
    .rpt                   (rpt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stall pattern: axis port 0 blocked, instance 0 blocked, instances 1-2 idle.
  task automatic set_stall(input bit on);
    if (on) begin
      axis_block = 2'b01;
      inst_idle  = 3'b110;
      inst_block = 3'b001;
    end else begin
      axis_block = 2'b00;
      inst_idle  = 3'b111;
      inst_block = 3'b000;
    end
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20; k++) begin
      if (rpt_if.rpt_valid) break;
      @(negedge clk);
    end
    chk(name, {31'd0, rpt_if.rpt_valid}, 32'd1);
  endtask

  function automatic logic [31:0] beat();
    return {22'd0, rpt_if.rpt_kind, rpt_if.rpt_idx, rpt_if.rpt_last};
  endfunction

  always @(negedge clk) begin
    if (rst_n && rpt_if.rpt_valid && rpt_if.rpt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", beat(), 32'hFFFF_FFFF);
      end else begin
        chk("sb_beat", beat(), {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    thresh = 16'd4;
    rpt_if.rpt_ready = 1'b0;
    set_stall(1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_block",  {31'd0, block}, 32'd0);
    chk("rst_detect", {24'd0, detect_cnt}, 32'd0);
    chk("rst_valid",  {31'd0, rpt_if.rpt_valid}, 32'd0);
    chk("rst_beat",   beat(), 32'd0);

    // Three stall cycles below threshold, break, three more: never reaches 4.
    step(); enable = 1'b1; set_stall(1'b1);
    repeat (3) step();
    set_stall(1'b0);
    @(negedge clk);
    chk("t1_block_3cyc", {31'd0, block}, 32'd0);
    step(); set_stall(1'b1);
    repeat (3) step();
    set_stall(1'b0);
    @(negedge clk);
    chk("t1_counter_reset", {31'd0, block}, 32'd0);

    // Detection at the 4th edge, full report drained with ready held high.
    step();
    rpt_if.rpt_ready = 1'b1;
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h201);
    set_stall(1'b1);
    repeat (3) step();
    @(negedge clk);
    chk("t2_block_pre", {31'd0, block}, 32'd0);
    step();
    set_stall(1'b0);
    @(negedge clk);
    chk("t2_block", {31'd0, block}, 32'd1);
    chk("t2_detect", {24'd0, detect_cnt}, 32'd1);
    repeat (8) step();
    @(negedge clk);
    chk("t3_done_valid", {31'd0, rpt_if.rpt_valid}, 32'd0);
    chk("t3_queue_empty", exp_q.size(), 32'd0);
    chk("t3_done_block", {31'd0, block}, 32'd1);
    step(); set_stall(1'b1);
    repeat (6) step();
    set_stall(1'b0);
    @(negedge clk);
    chk("done_no_redetect", {24'd0, detect_cnt}, 32'd1);

    // Clear, re-detect, then hold off the consumer.
    rpt_if.rpt_ready = 1'b0;
    step(); clear = 1'b1;
    step(); clear = 1'b0;
    @(negedge clk);
    chk("clear_block", {31'd0, block}, 32'd0);
    step(); set_stall(1'b1);
    repeat (4) step();
    set_stall(1'b0);
    @(negedge clk);
    chk("t4_block", {31'd0, block}, 32'd1);
    chk("t4_detect", {24'd0, detect_cnt}, 32'd2);
    wait_valid("t4_valid_rise");
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, rpt_if.rpt_valid}, 32'd1);
      chk("t4_hold_beat", beat(), 32'h000);
    end
    exp_q.push_back(10'h000);
    step(); rpt_if.rpt_ready = 1'b1;
    step(); rpt_if.rpt_ready = 1'b0;
    @(negedge clk);
    wait_valid("t5_beat1_valid");
    chk("t5_beat1", beat(), 32'h201);
    step(); clear = 1'b1;
    step(); clear = 1'b0;
    @(negedge clk);
    chk("t5_clear_block", {31'd0, block}, 32'd0);
    chk("t5_clear_valid", {31'd0, rpt_if.rpt_valid}, 32'd0);
    chk("t5_clear_detect", {24'd0, detect_cnt}, 32'd2);

    // Threshold of zero behaves as one: detection on the first stalled edge.
    step(); thresh = 16'd0; set_stall(1'b1);
    step(); set_stall(1'b0);
    @(negedge clk);
    chk("thr0_block", {31'd0, block}, 32'd1);
    chk("thr0_detect", {24'd0, detect_cnt}, 32'd3);

    // Asynchronous reset while scanning.
    rst_n = 1'b0;
    #1;
    chk("t6_block",  {31'd0, block}, 32'd0);
    chk("t6_detect", {24'd0, detect_cnt}, 32'd0);
    chk("t6_valid",  {31'd0, rpt_if.rpt_valid}, 32'd0);
    chk("t6_beat",   beat(), 32'd0);
    step(); rst_n = 1'b1;
    step();
    chk("end_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
